// File: rtl/harmonic_mixer_sequencer.sv
// ============================================================================
// Module      : harmonic_mixer_sequencer
// Description : Additive-synthesis sample sequencer. Per sample_tick it reads
//               a per-instrument harmonic descriptor from an external ROM,
//               fetches sine samples for harmonics 1..4 of the fundamental
//               phase, accumulates signed weighted sums, scales by 1/128 with
//               saturation and presents the result on a valid/ready port.
//               Optional macro HARMONIC_SKIP_ZERO_EN skips sine requests for
//               harmonics whose weight is zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module harmonic_mixer_sequencer #(
  parameter int PHASE_W = 16,
  parameter int SIN_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sample_tick,
  input  logic [2:0]                metadata,
  input  logic [PHASE_W-1:0]        phase,
  output logic [2:0]                rom_metadata,
  input  logic [31:0]               rom_dout,
  output logic                      sin_req,
  output logic [PHASE_W-1:0]        sin_addr,
  input  logic                      sin_ack,
  input  logic signed [SIN_W-1:0]   sin_data,
  output logic signed [SIN_W-1:0]   sample_out,
  output logic                      sample_valid,
  input  logic                      sample_ready,
  output logic                      busy,
  output logic                      overrun
);

  // Worst case |sin| * 127 * 4 needs SIN_W+9 bits; one spare bit of headroom.
  localparam int ACC_W = SIN_W + 10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ROM_RD = 3'd1,
    LOAD   = 3'd2,
    REQ    = 3'd3,
    SCALE  = 3'd4,
    OUT    = 3'd5
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [PHASE_W-1:0]      phase_q;
  logic [3:0][6:0]         weights;
  logic [3:0]              negs;
  logic [3:0]              pending;    // harmonics still to be fetched, bit0 = k=1
  logic signed [ACC_W-1:0] acc;

  logic [3:0][6:0]         rom_w;
  logic [3:0]              rom_neg;
  logic [3:0]              load_mask;
  logic [1:0]              cur;        // k-1 of the harmonic being fetched
  logic [3:0]              cur_onehot;
  logic signed [7:0]       w_s;
  logic signed [SIN_W+7:0] prod;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] shifted;
  logic [SIN_W-1:0]        sat;

  // Unpack the ROM word: {w1,w2,w3,w4,neg1,neg2,neg3,neg4}
  always_comb begin
    rom_w[0]   = rom_dout[31:25];
    rom_w[1]   = rom_dout[24:18];
    rom_w[2]   = rom_dout[17:11];
    rom_w[3]   = rom_dout[10:4];
    rom_neg[0] = rom_dout[3];
    rom_neg[1] = rom_dout[2];
    rom_neg[2] = rom_dout[1];
    rom_neg[3] = rom_dout[0];
`ifdef HARMONIC_SKIP_ZERO_EN
    load_mask  = {|rom_w[3], |rom_w[2], |rom_w[1], |rom_w[0]};
`else
    load_mask  = 4'b1111;
`endif
  end

  // Current harmonic is the lowest one still pending; address is phase*k mod 2^PHASE_W
  always_comb begin
    cur        = 2'd0;
    cur_onehot = 4'b0001;
    casez (pending)
      4'b???1: begin cur = 2'd0; cur_onehot = 4'b0001; end
      4'b??10: begin cur = 2'd1; cur_onehot = 4'b0010; end
      4'b?100: begin cur = 2'd2; cur_onehot = 4'b0100; end
      4'b1000: begin cur = 2'd3; cur_onehot = 4'b1000; end
      default: begin cur = 2'd0; cur_onehot = 4'b0001; end
    endcase
    case (cur)
      2'd0:    sin_addr = phase_q;
      2'd1:    sin_addr = phase_q << 1;
      2'd2:    sin_addr = phase_q + (phase_q << 1);
      default: sin_addr = phase_q << 2;
    endcase
  end

  // Signed weighted term and the floor-scaled, saturated result
  always_comb begin
    w_s     = signed'({1'b0, weights[cur]});
    prod    = sin_data * w_s;
    term    = negs[cur] ? -{{2{prod[SIN_W+7]}}, prod} : {{2{prod[SIN_W+7]}}, prod};
    shifted = acc >>> 7;
    if ((&shifted[ACC_W-1:SIN_W-1]) || (~|shifted[ACC_W-1:SIN_W-1]))
      sat = shifted[SIN_W-1:0];
    else if (acc[ACC_W-1])
      sat = {1'b1, {(SIN_W-1){1'b0}}};
    else
      sat = {1'b0, {(SIN_W-1){1'b1}}};
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt    = state;
    sin_req      = 1'b0;
    sample_valid = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE:   if (sample_tick) state_nxt = ROM_RD;
      ROM_RD: state_nxt = LOAD;
      LOAD:   state_nxt = (load_mask == 4'b0000) ? SCALE : REQ;
      REQ: begin
        sin_req = 1'b1;
        if (sin_ack && ((pending & ~cur_onehot) == 4'b0000)) state_nxt = SCALE;
      end
      SCALE:  state_nxt = OUT;
      OUT: begin
        sample_valid = 1'b1;
        if (sample_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch request, load descriptor, accumulate, scale
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_metadata <= '0;
      phase_q      <= '0;
      weights      <= '0;
      negs         <= '0;
      pending      <= '0;
      acc          <= '0;
      sample_out   <= '0;
    end else begin
      case (state)
        IDLE: if (sample_tick) begin
          rom_metadata <= metadata;
          phase_q      <= phase;
          acc          <= '0;
        end
        LOAD: begin
          weights <= rom_w;
          negs    <= rom_neg;
          pending <= load_mask;
        end
        REQ: if (sin_ack) begin
          acc     <= acc + term;
          pending <= pending & ~cur_onehot;
        end
        SCALE: sample_out <= signed'(sat);
        default: ;
      endcase
    end
  end

  // Sticky flag for ticks arriving while a sample is in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              overrun <= 1'b0;
    else if (sample_tick && state != IDLE) overrun <= 1'b1;
  end

endmodule

`default_nettype wire
